// File: rtl/mem_loader_pkg.sv
// Shared types and defaults for the image loader: FSM state encoding, halt code, default geometry.
package mem_loader_pkg;

  localparam int DEPTH_DEF = 512;
  localparam int AW_DEF    = 9;
  localparam int DW_DEF    = 32;

  // Wide enough for any supported word width; callers slice to DW.
  localparam logic [63:0] HALT_CODE = '1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    HALT = 3'd3,
    ERR  = 3'd4
  } state_t;

endpackage

// File: rtl/mem_loader_if.sv
// Image stream handshake plus data-memory write port of the loader.
interface mem_loader_if
  import mem_loader_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;

  // slave: the loader; master: the image source / memory side environment
  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/ml_sat_counter.sv
// Purpose: 32-bit up counter that sticks at all-ones; synchronous clear wins over enable.
// Latency: value reflects enable/clear one cycle later.
// Backpressure: none, free-running while enabled.
module ml_sat_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        clear,
  output logic [31:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clear) begin
      value <= '0;
    end else if (enable && (value != 32'hFFFF_FFFF)) begin
      value <= value + 32'd1;
    end
  end

endmodule

// File: rtl/mem_loader.sv
// Purpose: stream a program image into data memory, then release the CPU until it writes the halt code.
//   Optional MEM_LOADER_CHECKSUM_EN: final beat is a mod-2^DW checksum of the image, not written.
// Latency: each accepted beat writes memory exactly one cycle later; CPU released two cycles after final beat.
// Backpressure: in_ready is high only while loading; dropped on the final beat and on overflow/error.
module mem_loader
  import mem_loader_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              start_load,
  mem_loader_if.slave       bus,
  output logic              cpu_rst_n,
  input  logic [DW-1:0]     cpu_rd,
  output logic              halted,
  output logic              load_err,
  output logic [AW:0]       word_count,
  output logic [31:0]       cycle_count
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state;
  logic [AW-1:0] addr;
  logic          last_seen;
  logic          beat;
  logic          full;
  logic          restart;
  logic          wr_beat;

  assign beat    = bus.in_valid && bus.in_ready;
  assign full    = (word_count == DEPTH_W);
  assign restart = start_load && ((state == IDLE) || (state == HALT) || (state == ERR));

`ifdef MEM_LOADER_CHECKSUM_EN
  logic [DW-1:0] sum;

  assign wr_beat = beat && !full && !bus.in_last;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sum <= '0;
    end else if (restart) begin
      sum <= '0;
    end else if (wr_beat) begin
      sum <= sum + bus.in_data;
    end
  end
`else
  assign wr_beat = beat && !full;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state         <= IDLE;
      addr          <= '0;
      last_seen     <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_rst_n     <= 1'b0;
      halted        <= 1'b0;
      load_err      <= 1'b0;
      word_count    <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      if (restart) begin
        state        <= LOAD;
        addr         <= '0;
        last_seen    <= 1'b0;
        bus.in_ready <= 1'b1;
        cpu_rst_n    <= 1'b0;
        halted       <= 1'b0;
        load_err     <= 1'b0;
        word_count   <= '0;
      end else begin
        if (wr_beat) begin
          bus.mem_we    <= 1'b1;
          bus.mem_addr  <= addr;
          bus.mem_wdata <= bus.in_data;
          addr          <= addr + 1'b1;
          word_count    <= word_count + 1'b1;
        end
        unique case (state)
          LOAD: begin
            // Spend one cycle after the final beat so its write lands before the CPU runs.
            if (last_seen) begin
              state     <= RUN;
              cpu_rst_n <= 1'b1;
              last_seen <= 1'b0;
            end else if (beat) begin
              if (full) begin
                state        <= ERR;
                load_err     <= 1'b1;
                bus.in_ready <= 1'b0;
              end else if (bus.in_last) begin
                bus.in_ready <= 1'b0;
`ifdef MEM_LOADER_CHECKSUM_EN
                if (bus.in_data == sum) begin
                  last_seen <= 1'b1;
                end else begin
                  state    <= ERR;
                  load_err <= 1'b1;
                end
`else
                last_seen <= 1'b1;
`endif
              end
            end
          end
          RUN: begin
            if (cpu_rd == HALT_CODE[DW-1:0]) begin
              state     <= HALT;
              halted    <= 1'b1;
              cpu_rst_n <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // The halt-detect cycle is still RUN, so it is counted; HALT freezes the count.
  ml_sat_counter u_run_cnt (
    .clk    (CLK),
    .rst_n  (RSTn),
    .enable (state == RUN),
    .clear  (restart),
    .value  (cycle_count)
  );

endmodule

// File: tb/tb_mem_loader.sv
// Table-driven loads with a write scoreboard, plus hand sequences for overflow, restart and reset corners.
module tb_mem_loader;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          CLK;
  logic          RSTn;
  logic          start_load;
  logic          cpu_rst_n;
  logic [DW-1:0] cpu_rd;
  logic          halted;
  logic          load_err;
  logic [AW:0]   word_count;
  logic [31:0]   cycle_count;

  mem_loader_if #(.AW(AW), .DW(DW)) bus ();

  mem_loader #(.DEPTH(512), .AW(AW), .DW(DW)) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .start_load  (start_load),
    .bus         (bus),
    .cpu_rst_n   (cpu_rst_n),
    .cpu_rd      (cpu_rd),
    .halted      (halted),
    .load_err    (load_err),
    .word_count  (word_count),
    .cycle_count (cycle_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct {
    int          nwords;
    logic [31:0] base;
    int          halt_at;
    logic [31:0] exp_wc;
    logic [31:0] exp_cc;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[5];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    compared++;
    if (act !== exp_v) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Advance one clock and sample #1 after the edge; any write strobe is scored here.
  task automatic step();
    wr_t e;
    @(posedge CLK);
    #1;
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(bus.mem_addr), 64'(e.addr));
        chk("wr_data", 64'(bus.mem_wdata), 64'(e.data));
      end
    end
  endtask

  task automatic send(input logic [31:0] d, input logic last, input bit wr, input logic [AW-1:0] a);
    wr_t e;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    chk("beat_in_ready", 64'(bus.in_ready), 64'd1);
    if (wr) begin
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
    end
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (wr) begin
      chk("wr_issued", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
  endtask

  task automatic do_start();
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    chk("start_in_ready", 64'(bus.in_ready), 64'd1);
    chk("start_word_count", 64'(word_count), 64'd0);
    chk("start_cycle_count", 64'(cycle_count), 64'd0);
    chk("start_halted", 64'(halted), 64'd0);
    chk("start_load_err", 64'(load_err), 64'd0);
  endtask

  // Data word i is base*(i+1); with the checksum build a trailing checksum beat is appended.
  task automatic load_image(input int n, input logic [31:0] base, input bit bad_sum);
    logic [31:0] d;
    logic [31:0] sum;
    sum = '0;
    for (int i = 0; i < n; i++) begin
      d   = base * (i + 1);
      sum = sum + d;
`ifdef MEM_LOADER_CHECKSUM_EN
      send(d, 1'b0, 1'b1, AW'(i));
`else
      send(d, (i == n - 1), 1'b1, AW'(i));
`endif
    end
`ifdef MEM_LOADER_CHECKSUM_EN
    send(bad_sum ? sum + 32'd1 : sum, 1'b1, 1'b0, '0);
`else
    if (bad_sum) chk("bad_sum_unsupported", 64'(n), 64'(n + 1));
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_mem_we"}, 64'(bus.mem_we), 64'd0);
    chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(bus.mem_wdata), 64'd0);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    chk({tag, "_cpu_rst_n"}, 64'(cpu_rst_n), 64'd0);
    chk({tag, "_halted"}, 64'(halted), 64'd0);
    chk({tag, "_load_err"}, 64'(load_err), 64'd0);
    chk({tag, "_word_count"}, 64'(word_count), 64'd0);
    chk({tag, "_cycle_count"}, 64'(cycle_count), 64'd0);
  endtask

  initial begin
    vecs[0] = '{4,  32'h0000_0011, 10, 32'd4,  32'd10};
    vecs[1] = '{1,  32'hDEAD_0001, 1,  32'd1,  32'd1};
    vecs[2] = '{7,  32'h0101_0101, 3,  32'd7,  32'd3};
    vecs[3] = '{16, 32'hF000_0001, 25, 32'd16, 32'd25};
    vecs[4] = '{2,  32'h8000_0000, 2,  32'd2,  32'd2};

    RSTn         = 1'b0;
    start_load   = 1'b0;
    cpu_rd       = '0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    step();
    check_reset_vals("rst");
    RSTn = 1'b1;
    step();

    // A beat offered while idle must be ignored.
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hCAFE_F00D;
    step();
    bus.in_valid = 1'b0;
    chk("idle_word_count", 64'(word_count), 64'd0);
    chk("idle_in_ready", 64'(bus.in_ready), 64'd0);

    for (int v = 0; v < 5; v++) begin
      do_start();
      load_image(vecs[v].nwords, vecs[v].base, 1'b0);
      chk("pre_release_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
      chk("load_word_count", 64'(word_count), 64'(vecs[v].exp_wc));
      chk("last_in_ready", 64'(bus.in_ready), 64'd0);
      step();
      chk("release_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
      chk("release_cycle_count", 64'(cycle_count), 64'd0);
      repeat (vecs[v].halt_at - 1) step();
      chk("pre_halt_cycle_count", 64'(cycle_count), 64'(vecs[v].halt_at - 1));
      cpu_rd = '1;
      step();
      cpu_rd = '0;
      chk("halt_halted", 64'(halted), 64'd1);
      chk("halt_cycle_count", 64'(cycle_count), 64'(vecs[v].exp_cc));
      chk("halt_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
      repeat (3) step();
      chk("frozen_cycle_count", 64'(cycle_count), 64'(vecs[v].exp_cc));
      chk("frozen_halted", 64'(halted), 64'd1);
    end

    // start_load ignored in LOAD and RUN, honoured in HALT.
    do_start();
    send(32'hA1, 1'b0, 1'b1, 9'd0);
    send(32'hA2, 1'b0, 1'b1, 9'd1);
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    chk("load_start_word_count", 64'(word_count), 64'd2);
    chk("load_start_in_ready", 64'(bus.in_ready), 64'd1);
    send(32'hA3, 1'b0, 1'b1, 9'd2);
`ifdef MEM_LOADER_CHECKSUM_EN
    send(32'hA4, 1'b0, 1'b1, 9'd3);
    send(32'h28A, 1'b1, 1'b0, '0);
`else
    send(32'hA4, 1'b1, 1'b1, 9'd3);
`endif
    step();
    chk("seq_release", 64'(cpu_rst_n), 64'd1);
    repeat (2) step();
    start_load = 1'b1;
    step();
    start_load = 1'b0;
    chk("run_start_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
    chk("run_start_cycle_count", 64'(cycle_count), 64'd3);
    chk("run_start_in_ready", 64'(bus.in_ready), 64'd0);
    chk("run_start_word_count", 64'(word_count), 64'd4);
    repeat (2) step();
    cpu_rd = '1;
    step();
    cpu_rd = '0;
    chk("seq_halt_cycle_count", 64'(cycle_count), 64'd6);
    chk("seq_halted", 64'(halted), 64'd1);
    do_start();
    chk("halt_restart_cpu_rst_n", 64'(cpu_rst_n), 64'd0);

    // Overflow: 512 writes accepted, the 513th beat dropped and the load errors out.
    for (int i = 0; i < 512; i++) begin
      send(32'h1000_0000 + 32'(i), 1'b0, 1'b1, AW'(i));
    end
    chk("full_word_count", 64'(word_count), 64'd512);
    send(32'hBAD0_0BAD, 1'b0, 1'b0, '0);
    chk("ovf_load_err", 64'(load_err), 64'd1);
    chk("ovf_in_ready", 64'(bus.in_ready), 64'd0);
    chk("ovf_word_count", 64'(word_count), 64'd512);
    chk("ovf_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    repeat (2) step();
    chk("err_sticky", 64'(load_err), 64'd1);
    do_start();

    // Reset in the cycle after a beat kills the strobe and all state at once.
    send(32'h5A5A_5A5A, 1'b0, 1'b1, 9'd0);
    RSTn = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    step();
    check_reset_vals("held_rst");
    RSTn = 1'b1;
    step();
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'd0);

`ifdef MEM_LOADER_CHECKSUM_EN
    do_start();
    load_image(3, 32'd1, 1'b1);
    chk("cs_bad_load_err", 64'(load_err), 64'd1);
    chk("cs_bad_word_count", 64'(word_count), 64'd3);
    chk("cs_bad_in_ready", 64'(bus.in_ready), 64'd0);
    repeat (2) step();
    chk("cs_bad_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
`endif

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
